alsu_gen: RTL and testbench

Parametrised, pipelined arithmetic/logic/shift unit that replaces the fixed 3-bit ALSU. Operand width and LED width are generics, and input transactions are qualified by a valid strobe. The block adds an output-valid flag and a saturating invalid-transaction counter. It sits between the operand/control register bank and the result bus and status LEDs.

---
 rtl/alsu_gen_pkg.sv | 34 +++
 rtl/alsu_gen_dp.sv | 72 +++++++
 rtl/alsu_gen.sv | 129 ++++++++++++
 tb/tb_alsu_gen.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alsu_gen_pkg.sv
// Shared opcode encoding, error-counter width and the invalid-transaction rule.
// Build option ALSU_SUB_EN: when defined, opcode 6 is SUB instead of invalid.
package alsu_gen_pkg;

  typedef enum logic [2:0] {
    OR        = 3'd0,
    XOR       = 3'd1,
    ADD       = 3'd2,
    MULT      = 3'd3,
    SHIFT     = 3'd4,
    ROTATE    = 3'd5,
    SUB       = 3'd6,
    INVALID_7 = 3'd7
  } opcode_e;

  localparam int ERR_CNT_W = 8;

  // Reduction flags are only meaningful for OR/XOR; any other use is an error.
  function automatic logic alsu_is_invalid(input logic [2:0] op,
                                           input logic       red_a,
                                           input logic       red_b);
    logic inv;
    case (opcode_e'(op))
      OR, XOR:                  inv = 1'b0;
      ADD, MULT, SHIFT, ROTATE: inv = red_a | red_b;
`ifdef ALSU_SUB_EN
      SUB:                      inv = red_a | red_b;
`endif
      default:                  inv = 1'b1;
    endcase
    return inv;
  endfunction

endpackage

// File: rtl/alsu_gen_dp.sv
// Combinational ALSU datapath: stage-1 operands plus the held result give the next result.
// Build option ALSU_SUB_EN enables the SUB path for opcode 6.
module alsu_gen_dp
  import alsu_gen_pkg::*;
#(
  parameter int    WIDTH          = 3,
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON"
) (
  input  logic [2:0]         i_opcode,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic               i_cin,
  input  logic               i_sin,
  input  logic               i_dir,
  input  logic               i_red_a,
  input  logic               i_red_b,
  input  logic               i_byp_a,
  input  logic               i_byp_b,
  input  logic [2*WIDTH-1:0] i_out,
  output logic [2*WIDTH-1:0] o_next_out,
  output logic               o_invalid
);

  localparam int OUT_W   = 2 * WIDTH;
  localparam bit PRI_B   = (INPUT_PRIORITY == "B");
  localparam bit USE_CIN = (FULL_ADDER == "ON");

  logic signed [OUT_W-1:0] w_a_ext;
  logic signed [OUT_W-1:0] w_b_ext;
  logic signed [OUT_W-1:0] w_cin_ext;
  logic signed [OUT_W-1:0] w_byp;
  logic        [WIDTH-1:0] w_red_src;
  logic                    w_red_any;
  logic signed [OUT_W-1:0] w_result;

  assign w_a_ext   = {{(OUT_W-WIDTH){i_a[WIDTH-1]}}, i_a};
  assign w_b_ext   = {{(OUT_W-WIDTH){i_b[WIDTH-1]}}, i_b};
  assign w_cin_ext = {{(OUT_W-1){1'b0}}, i_cin & USE_CIN};

  // A wins unless both flags are set and B has priority.
  assign w_red_src = (i_red_a && !(i_red_b && PRI_B)) ? i_a : i_b;
  assign w_byp     = (i_byp_a && !(i_byp_b && PRI_B)) ? w_a_ext : w_b_ext;
  assign w_red_any = i_red_a | i_red_b;

  assign o_invalid = alsu_is_invalid(i_opcode, i_red_a, i_red_b);

  always_comb begin
    w_result = '0;
    if (o_invalid) begin
      w_result = '0;
    end else if (i_byp_a || i_byp_b) begin
      w_result = w_byp;
    end else begin
      case (opcode_e'(i_opcode))
        OR:      w_result = w_red_any ? {{(OUT_W-1){1'b0}}, |w_red_src} : (w_a_ext | w_b_ext);
        XOR:     w_result = w_red_any ? {{(OUT_W-1){1'b0}}, ^w_red_src} : (w_a_ext ^ w_b_ext);
        ADD:     w_result = w_a_ext + w_b_ext + w_cin_ext;
        MULT:    w_result = w_a_ext * w_b_ext;
        SHIFT:   w_result = i_dir ? {i_out[OUT_W-2:0], i_sin} : {i_sin, i_out[OUT_W-1:1]};
        ROTATE:  w_result = i_dir ? {i_out[OUT_W-2:0], i_out[OUT_W-1]} : {i_out[0], i_out[OUT_W-1:1]};
`ifdef ALSU_SUB_EN
        SUB:     w_result = w_a_ext - w_b_ext - w_cin_ext;
`endif
        default: w_result = '0;
      endcase
    end
  end

  assign o_next_out = w_result;

endmodule

// File: rtl/alsu_gen.sv
// Two-stage pipelined ALSU top: input capture, result/LED/error-counter registers.
// Build option ALSU_SUB_EN (see alsu_gen_pkg) makes opcode 6 a subtract.
module alsu_gen
  import alsu_gen_pkg::*;
#(
  parameter int    WIDTH          = 3,
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON",
  parameter int    LED_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [2:0]           opcode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 cin_in,
  input  logic                 serial_in,
  input  logic                 direction,
  input  logic                 red_op_A,
  input  logic                 red_op_B,
  input  logic                 bypass_A,
  input  logic                 bypass_B,
  output logic [2*WIDTH-1:0]   out,
  output logic                 out_valid,
  output logic [LED_W-1:0]     leds,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int OUT_W = 2 * WIDTH;

  logic                    r_vld_p1;
  logic [2:0]              r_opcode_p1;
  logic signed [WIDTH-1:0] r_a_p1;
  logic signed [WIDTH-1:0] r_b_p1;
  logic                    r_cin_p1;
  logic                    r_sin_p1;
  logic                    r_dir_p1;
  logic                    r_red_a_p1;
  logic                    r_red_b_p1;
  logic                    r_byp_a_p1;
  logic                    r_byp_b_p1;

  logic signed [OUT_W-1:0] r_out_p2;
  logic                    r_vld_p2;
  logic [LED_W-1:0]        r_leds;
  logic [ERR_CNT_W-1:0]    r_err_cnt;

  logic [OUT_W-1:0]        w_next_out;
  logic                    w_invalid;

  // Stage 1: capture operands only on valid cycles; a bubble just drops the valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1    <= 1'b0;
      r_opcode_p1 <= '0;
      r_a_p1      <= '0;
      r_b_p1      <= '0;
      r_cin_p1    <= 1'b0;
      r_sin_p1    <= 1'b0;
      r_dir_p1    <= 1'b0;
      r_red_a_p1  <= 1'b0;
      r_red_b_p1  <= 1'b0;
      r_byp_a_p1  <= 1'b0;
      r_byp_b_p1  <= 1'b0;
    end else begin
      r_vld_p1 <= in_valid;
      if (in_valid) begin
        r_opcode_p1 <= opcode;
        r_a_p1      <= A;
        r_b_p1      <= B;
        r_cin_p1    <= cin_in;
        r_sin_p1    <= serial_in;
        r_dir_p1    <= direction;
        r_red_a_p1  <= red_op_A;
        r_red_b_p1  <= red_op_B;
        r_byp_a_p1  <= bypass_A;
        r_byp_b_p1  <= bypass_B;
      end
    end
  end

  alsu_gen_dp #(
    .WIDTH          (WIDTH),
    .INPUT_PRIORITY (INPUT_PRIORITY),
    .FULL_ADDER     (FULL_ADDER)
  ) u_dp (
    .i_opcode   (r_opcode_p1),
    .i_a        (r_a_p1),
    .i_b        (r_b_p1),
    .i_cin      (r_cin_p1),
    .i_sin      (r_sin_p1),
    .i_dir      (r_dir_p1),
    .i_red_a    (r_red_a_p1),
    .i_red_b    (r_red_b_p1),
    .i_byp_a    (r_byp_a_p1),
    .i_byp_b    (r_byp_b_p1),
    .i_out      (r_out_p2),
    .o_next_out (w_next_out),
    .o_invalid  (w_invalid)
  );

  // Stage 2: result, status LEDs and error counter move only for a captured transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_p2  <= '0;
      r_vld_p2  <= 1'b0;
      r_leds    <= '0;
      r_err_cnt <= '0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_out_p2 <= w_next_out;
        if (w_invalid) begin
          r_leds <= ~r_leds;
          if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
        end else begin
          r_leds <= '0;
        end
      end
    end
  end

  assign out       = r_out_p2;
  assign out_valid = r_vld_p2;
  assign leds      = r_leds;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_alsu_gen.sv
// Testbench for alsu_gen at WIDTH=3: directed steps plus random traffic against an integer model.
module tb_alsu_gen;
  import alsu_gen_pkg::*;

  localparam int WIDTH = 3;
  localparam int OUT_W = 2 * WIDTH;
  localparam int LED_W = 16;
  localparam int MASK  = (1 << OUT_W) - 1;
  localparam int AMASK = (1 << WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic [2:0]           opcode = '0;
  logic [WIDTH-1:0]     A = '0;
  logic [WIDTH-1:0]     B = '0;
  logic                 cin_in = 1'b0;
  logic                 serial_in = 1'b0;
  logic                 direction = 1'b0;
  logic                 red_op_A = 1'b0;
  logic                 red_op_B = 1'b0;
  logic                 bypass_A = 1'b0;
  logic                 bypass_B = 1'b0;
  logic [OUT_W-1:0]     out;
  logic                 out_valid;
  logic [LED_W-1:0]     leds;
  logic [ERR_CNT_W-1:0] err_cnt;

  alsu_gen #(
    .WIDTH          (WIDTH),
    .INPUT_PRIORITY ("A"),
    .FULL_ADDER     ("ON"),
    .LED_W          (LED_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .opcode    (opcode),
    .A         (A),
    .B         (B),
    .cin_in    (cin_in),
    .serial_in (serial_in),
    .direction (direction),
    .red_op_A  (red_op_A),
    .red_op_B  (red_op_B),
    .bypass_A  (bypass_A),
    .bypass_B  (bypass_B),
    .out       (out),
    .out_valid (out_valid),
    .leds      (leds),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op, a, b, cin, sin, dir, ra, rb, ba, bb;
  } txn_t;

  int               n_vec = 0;
  int               n_bad = 0;
  txn_t             pend;
  int               pend_vld = 0;
  int               m_out = 0;
  int               m_ovld = 0;
  int               m_err = 0;
  logic [LED_W-1:0] m_leds = '0;

  function automatic int m_invalid(txn_t t);
    int red = (t.ra != 0 || t.rb != 0) ? 1 : 0;
    if (t.op == 7) return 1;
    if (t.op == 6) begin
`ifdef ALSU_SUB_EN
      return red;
`else
      return 1;
`endif
    end
    if (t.op <= 1) return 0;
    return red;
  endfunction

  function automatic int m_result(txn_t t, int prev);
    int sel;
    if (m_invalid(t) != 0) return 0;
    if (t.ba != 0) return t.a & MASK;
    if (t.bb != 0) return t.b & MASK;
    case (t.op)
      0, 1: begin
        if (t.ra != 0 || t.rb != 0) begin
          sel = ((t.ra != 0) ? t.a : t.b) & AMASK;
          if (t.op == 0) return (sel != 0) ? 1 : 0;
          return $countones(sel) % 2;
        end
        return ((t.op == 0) ? (t.a | t.b) : (t.a ^ t.b)) & MASK;
      end
      2: return (t.a + t.b + t.cin) & MASK;
      3: return (t.a * t.b) & MASK;
      4: return (t.dir != 0) ? (((prev << 1) | t.sin) & MASK) : ((t.sin << (OUT_W-1)) | (prev >> 1));
      5: return (t.dir != 0) ? (((prev << 1) | (prev >> (OUT_W-1))) & MASK)
                             : (((prev & 1) << (OUT_W-1)) | (prev >> 1));
      6: return (t.a - t.b - t.cin) & MASK;
      default: return 0;
    endcase
  endfunction

  task automatic m_reset();
    pend_vld = 0;
    m_out    = 0;
    m_ovld   = 0;
    m_err    = 0;
    m_leds   = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int op, input int a, input int b, input int cin, input int sin,
                       input int dir, input int ra, input int rb, input int ba, input int bb);
    in_valid  = 1'b1;
    opcode    = op[2:0];
    A         = a[WIDTH-1:0];
    B         = b[WIDTH-1:0];
    cin_in    = cin[0];
    serial_in = sin[0];
    direction = dir[0];
    red_op_A  = ra[0];
    red_op_B  = rb[0];
    bypass_A  = ba[0];
    bypass_B  = bb[0];
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_reset();
    end else begin
      m_ovld = pend_vld;
      if (pend_vld != 0) begin
        if (m_invalid(pend) != 0) begin
          m_leds = ~m_leds;
          if (m_err < 255) m_err++;
        end else begin
          m_leds = '0;
        end
        m_out = m_result(pend, m_out);
      end
      pend_vld = in_valid ? 1 : 0;
      if (in_valid) begin
        pend.op  = int'(opcode);
        pend.a   = int'($signed(A));
        pend.b   = int'($signed(B));
        pend.cin = int'(cin_in);
        pend.sin = int'(serial_in);
        pend.dir = int'(direction);
        pend.ra  = int'(red_op_A);
        pend.rb  = int'(red_op_B);
        pend.ba  = int'(bypass_A);
        pend.bb  = int'(bypass_B);
      end
    end
    #1;
    chk("out", 32'(out), 32'(m_out));
    chk("out_valid", 32'(out_valid), 32'(m_ovld));
    chk("leds", 32'(leds), 32'(m_leds));
    chk("err_cnt", 32'(err_cnt), 32'(m_err));
  endtask

  initial begin
    m_reset();
    tick();
    tick();
    chk("reset_out", 32'(out), 32'd0);
    rst_n = 1'b1;

    // ADD 3+2+1 then MULT -4*3, back to back
    drive(int'(ADD), 3, 2, 1, 0, 0, 0, 0, 0, 0);
    tick();
    chk("first_edge_vld", 32'(out_valid), 32'd0);
    drive(int'(MULT), -4, 3, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("add_out", 32'(out), 32'b000110);
    chk("add_vld", 32'(out_valid), 32'd1);
    idle();
    tick();
    chk("mult_out", 32'(out), 32'b110100);
    tick();
    chk("gap_vld", 32'(out_valid), 32'd0);
    chk("gap_hold", 32'(out), 32'b110100);

    // three invalid reductions on ADD, then a valid OR
    for (int i = 0; i < 3; i++) begin
      drive(int'(ADD), 1, 1, 0, 0, 0, 1, 0, 0, 0);
      tick();
    end
    drive(int'(OR), 1, 2, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("inv_out", 32'(out), 32'd0);
    chk("inv_leds", 32'(leds), 32'hFFFF);
    chk("inv_err", 32'(err_cnt), 32'd3);
    idle();
    tick();
    chk("or_leds", 32'(leds), 32'd0);

    // 5, then SHIFT left with 1, then ROTATE right
    drive(int'(ADD), 2, 2, 1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(int'(SHIFT), 0, 0, 0, 1, 1, 0, 0, 0, 0);
    tick();
    chk("pre_shift", 32'(out), 32'b000101);
    drive(int'(ROTATE), 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("shift_out", 32'(out), 32'b001011);
    idle();
    tick();
    chk("rot_out", 32'(out), 32'b100101);

    // bypass priority, gap, then B-only bypass of a negative operand
    drive(int'(XOR), 2, 1, 0, 0, 0, 0, 0, 1, 1);
    tick();
    idle();
    tick();
    chk("byp_out", 32'(out), 32'd2);
    tick();
    chk("byp_gap_vld", 32'(out_valid), 32'd0);
    drive(int'(ADD), 1, -1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    idle();
    tick();
    chk("bypb_out", 32'(out), 32'b111111);

    // opcode 6
    drive(6, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    tick();
    idle();
    tick();
`ifdef ALSU_SUB_EN
    chk("op6_out", 32'(out), 32'b111110);
`else
    chk("op6_out", 32'(out), 32'd0);
    chk("op6_leds", 32'(leds), 32'hFFFF);
`endif

    // error counter saturation
    for (int i = 0; i < 260; i++) begin
      drive(7, int'($urandom_range(7)), int'($urandom_range(7)), 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    idle();
    tick();
    chk("err_sat", 32'(err_cnt), 32'd255);

    // asynchronous reset with a transaction in flight
    drive(int'(ADD), 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(int'(MULT), 3, 3, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("arst_out", 32'(out), 32'd0);
    chk("arst_vld", 32'(out_valid), 32'd0);
    chk("arst_leds", 32'(leds), 32'd0);
    chk("arst_err", 32'(err_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    drive(int'(ADD), 3, 2, 1, 0, 0, 0, 0, 0, 0);
    tick();
    chk("post_rst_vld", 32'(out_valid), 32'd0);
    idle();
    tick();
    chk("post_rst_out", 32'(out), 32'b000110);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) != 0)
        drive(int'($urandom_range(7)), int'($urandom_range(7)), int'($urandom_range(7)),
              int'($urandom_range(1)), int'($urandom_range(1)), int'($urandom_range(1)),
              ($urandom_range(5) == 0) ? 1 : 0, ($urandom_range(5) == 0) ? 1 : 0,
              ($urandom_range(7) == 0) ? 1 : 0, ($urandom_range(7) == 0) ? 1 : 0);
      else
        idle();
      tick();
    end
    idle();
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
